// File: rtl/fetch_unit.sv
// fetch_unit: program counter, single-outstanding imem req/ack fetch and prefetch FIFO with redirect flush.
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [15:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  output logic          inst_valid,
  output logic [15:0]   inst,
  output logic [15:0]   inst_pc,
  input  logic          inst_ready,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  output logic [CW-1:0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [15:0] fetch_pc, addr_nx;
  logic [15:0] mem_pc [DEPTH];
  logic [15:0] mem_in [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count, count_nx;
  logic push, pop, space;
  assign inst_valid = count != '0;
  assign inst = inst_valid ? mem_in[rd] : '0;
  assign inst_pc = inst_valid ? mem_pc[rd] : '0;
  assign imem_req = state != IDLE;
  assign fifo_count = count;
  assign pop = inst_valid & inst_ready & ~redirect;
  assign push = (state == WAIT) & imem_ack & ~redirect;
  assign count_nx = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign space = count_nx < FULL;
  // A redirect with the request still unacked must hold that request until the stale ack arrives.
  always_comb begin
    state_nx = state;
    addr_nx = imem_addr;
    if (redirect) begin
      state_nx = (state == IDLE || imem_ack) ? WAIT : DROP;
      addr_nx = (state == IDLE || imem_ack) ? redirect_pc : imem_addr;
    end else if (state == IDLE) begin
      state_nx = space ? WAIT : IDLE;
      addr_nx = space ? fetch_pc : imem_addr;
    end else if (imem_ack) begin
      state_nx = (state == DROP || space) ? WAIT : IDLE;
      addr_nx = (state == DROP) ? fetch_pc : imem_addr + 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      imem_addr <= '0;
      fetch_pc <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      imem_addr <= addr_nx;
      count <= count_nx;
      fetch_pc <= redirect ? redirect_pc : push ? imem_addr + 16'd1 : fetch_pc;
      rd <= redirect ? '0 : rd + AW'(pop);
      wr <= redirect ? '0 : wr + AW'(push);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr] <= imem_addr;
      mem_in[wr] <= imem_data;
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit single-cycle CPU. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers fetched words in a small prefetch FIFO. Decode consumes the FIFO through a valid/ready interface. A redirect input from the execute stage carries jump and branch targets, flushes the FIFO and restarts fetch at the new address.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- imem_req  out  1  read request to instruction memory; registered.
- imem_addr  out  16  word address of the request; registered, stable while imem_req=1.
- imem_ack  in  1  memory accepts the request and returns data this cycle; ignored when imem_req=0.
- imem_data  in  16  instruction word; valid only when imem_ack=1.
- inst_valid  out  1  FIFO head is valid (FIFO not empty).
- inst  out  16  FIFO head instruction.
- inst_pc  out  16  address of the FIFO head instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  pipeline redirect (jump or taken branch).
- redirect_pc  in  16  new fetch address; sampled when redirect=1.
- fifo_count  out  CW  number of valid FIFO entries.

## Operation
- State registers:
  - fetch_pc (16 bit), address of the next request.
  - FSM with states IDLE, WAIT and DROP.
  - FIFO of DEPTH entries, each holding {pc[15:0], instr[15:0]}, with read and write pointers and a count.
- At most one memory request is outstanding. imem_req=1 exactly when the FSM is in WAIT or DROP. imem_addr holds the address of the outstanding request.
- Pop: happens when inst_valid and inst_ready are both 1. It advances the read pointer. inst and inst_pc are combinational from the head entry.
- Push: happens on imem_ack in WAIT. It writes {imem_addr, imem_data} at the write pointer. fetch_pc becomes imem_addr+1, using 16-bit wrap (0xFFFF+1 = 0x0000).
- Space rule: count_next = count + push - pop. A request is issued only when count_next < DEPTH. A full FIFO therefore can never receive a push.
- Transitions when redirect=0:
  - IDLE to WAIT when count_next < DEPTH; imem_addr is set to fetch_pc.
  - WAIT with no ack: stay in WAIT.
  - WAIT with ack: push. Go to WAIT with imem_addr = imem_addr+1 if count_next < DEPTH, otherwise go to IDLE.
  - DROP with no ack: stay in DROP.
  - DROP with ack: discard the data. Go to WAIT with imem_addr = fetch_pc (the FIFO is empty at this point).
- Transitions when redirect=1 (this has priority over push and pop in the same cycle):
  - The FIFO is flushed (count=0, pointers equal) and fetch_pc is set to redirect_pc.
  - Any pop in the same cycle is void.
  - Any ack data in the same cycle is discarded and nothing is pushed.
  - IDLE, or WAIT/DROP with ack: go to WAIT with imem_addr = redirect_pc.
  - WAIT/DROP with no ack: go to DROP. The request is held at its old address until it is acked, then discarded.
- Jump-target formation belongs to execute; redirect_pc arrives as a full 16-bit word.

## Timing
- Reset values (asynchronous, held while rst=1):
  - fetch_pc=0, state IDLE, FIFO empty, count=0.
  - imem_req=0, imem_addr=0.
  - inst_valid=0, fifo_count=0. inst and inst_pc read 0.
- After rst is released, the first edge moves IDLE to WAIT, so imem_req=1 with imem_addr=0 in the following cycle.
- Ack-to-output latency is 1 cycle. An ack sampled at edge k makes the entry visible, with inst_valid=1, after edge k.
- Throughput is one instruction per cycle when imem_ack=1 every cycle and decode pops every cycle.
- Redirect-to-first-instruction latency is 2 cycles with zero-wait memory: WAIT at redirect_pc after edge r, ack at edge r+1, inst_valid after edge r+1. DROP adds the wait for the stale ack.
- Reset asserted mid-request returns the block to its reset state immediately; the memory must tolerate an abandoned request.
- fifo_count is registered and updates on the same edge as push, pop and flush.

## Test plan
- Reset, then ack every cycle with imem_data = 0x1000+addr and inst_ready=1 → inst_pc sequence 0,1,2,…, inst = 0x1000,0x1001,…; inst_valid continuous from the 2nd cycle after the first request.
- inst_ready=0 and ack every cycle, DEPTH=4 → fifo_count reaches 4 and imem_req drops to 0 with imem_addr=4 last acked+1 pending. When ready is raised, 4 pops occur in order, then fetch resumes at 0x0004.
- Redirect to 0x0120 while in WAIT with ack withheld for 3 cycles → state goes to DROP, the stale data is not pushed, the next request has address 0x0120, and the first delivered inst_pc=0x0120.
- Redirect in the same cycle as ack and pop with FIFO count 2 → fifo_count=0 next cycle, the acked word is lost, and imem_addr=redirect_pc next cycle.
- Redirect to 0xFFFE with continuous acks → inst_pc sequence 0xFFFE, 0xFFFF, 0x0000.
- Assert rst for 1 cycle while in WAIT with FIFO count 3 → imem_req=0, inst_valid=0 and fifo_count=0 immediately. After release, fetch restarts at 0x0000.
